// File: rtl/word_writer.sv
// Stores one 16-bit word into an 8-bit memory as two byte writes.
// The byte order is set by HI_FIRST, and the second byte goes to the next (wrapping) address.
module word_writer #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned HI_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       word,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    input  logic              mem_rdy,
    output logic              wr,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              done
);

    localparam bit HiFirst = (HI_FIRST != 0);

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StSecond
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        data_d     = data_q;
        addr_out_d = addr_out_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The first byte is taken straight from the inputs so wr rises on the accept edge.
                if (start && ready_q) begin
                    state_d    = StFirst;
                    word_d     = word;
                    addr_d     = addr;
                    wr_d       = 1'b1;
                    data_d     = HiFirst ? word[15:8] : word[7:0];
                    addr_out_d = addr;
                    ready_d    = 1'b0;
                end
            end
            StFirst: begin
                if (mem_rdy) begin
                    state_d    = StSecond;
                    data_d     = HiFirst ? word_q[7:0] : word_q[15:8];
                    addr_out_d = addr_q + ADDR_W'(1);
                end
            end
            StSecond: begin
                if (mem_rdy) begin
                    state_d = StIdle;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                wr_d    = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            word_q     <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            addr_out_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            addr_out_q <= addr_out_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready    = ready_q;
    assign wr       = wr_q;
    assign data_out = data_q;
    assign addr_out = addr_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_word_writer.sv
// Table-driven bench for word_writer: one high-byte-first instance driven cycle by cycle
// from a vector table, plus one low-byte-first instance exercised by a short hand sequence.
module tb_word_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mem_rdy;
    logic [15:0] word;
    logic [12:0] addr;
    logic        ready, wr, done;
    logic [7:0]  data_out;
    logic [12:0] addr_out;

    logic        start_lo, mem_rdy_lo;
    logic [15:0] word_lo;
    logic [12:0] addr_lo;
    logic        ready_lo, wr_lo, done_lo;
    logic [7:0]  data_out_lo;
    logic [12:0] addr_out_lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    word_writer #(.ADDR_W(13), .HI_FIRST(1)) dut (
        .clk(clk), .rst(rst), .start(start), .word(word), .addr(addr), .ready(ready),
        .mem_rdy(mem_rdy), .wr(wr), .data_out(data_out), .addr_out(addr_out), .done(done)
    );

    word_writer #(.ADDR_W(13), .HI_FIRST(0)) dut_lo (
        .clk(clk), .rst(rst), .start(start_lo), .word(word_lo), .addr(addr_lo),
        .ready(ready_lo), .mem_rdy(mem_rdy_lo), .wr(wr_lo), .data_out(data_out_lo),
        .addr_out(addr_out_lo), .done(done_lo)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] word;
        logic [12:0] addr;
        logic        mem_rdy;
        logic        e_wr;
        logic [7:0]  e_data;
        logic [12:0] e_addr;
        logic        e_ready;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic [15:0] w,
                                input logic [12:0] a, input logic m, input logic ewr,
                                input logic [7:0] ed, input logic [12:0] ea,
                                input logic erdy, input logic edone);
        vec_t v;
        v.rst = r; v.start = s; v.word = w; v.addr = a; v.mem_rdy = m;
        v.e_wr = ewr; v.e_data = ed; v.e_addr = ea; v.e_ready = erdy; v.e_done = edone;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; word = '0; addr = '0; mem_rdy = 1'b0;
        start_lo = 1'b0; word_lo = '0; addr_lo = '0; mem_rdy_lo = 1'b0;

        //   rst  start word      addr      mrdy | wr  data   addr      rdy done
        add(1'b1, 1'b0, 16'h0000, 13'h0000, 1'b0, 1'b0, 8'h00, 13'h0000, 1'b1, 1'b0); // 0 reset
        // Basic word A55A at 0x0100
        add(1'b0, 1'b1, 16'hA55A, 13'h0100, 1'b1, 1'b1, 8'hA5, 13'h0100, 1'b0, 1'b0); // 1
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b1, 8'h5A, 13'h0101, 1'b0, 1'b0); // 2
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b0, 8'h5A, 13'h0101, 1'b1, 1'b1); // 3
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b0, 8'h5A, 13'h0101, 1'b1, 1'b0); // 4
        // Stall in FIRST for 3 cycles while the inputs wiggle
        add(1'b0, 1'b1, 16'hA55A, 13'h0100, 1'b0, 1'b1, 8'hA5, 13'h0100, 1'b0, 1'b0); // 5
        add(1'b0, 1'b1, 16'hFFFF, 13'h0ABC, 1'b0, 1'b1, 8'hA5, 13'h0100, 1'b0, 1'b0); // 6
        add(1'b0, 1'b1, 16'hFFFF, 13'h0ABC, 1'b0, 1'b1, 8'hA5, 13'h0100, 1'b0, 1'b0); // 7
        add(1'b0, 1'b0, 16'hFFFF, 13'h0ABC, 1'b0, 1'b1, 8'hA5, 13'h0100, 1'b0, 1'b0); // 8
        add(1'b0, 1'b0, 16'hFFFF, 13'h0ABC, 1'b1, 1'b1, 8'h5A, 13'h0101, 1'b0, 1'b0); // 9
        add(1'b0, 1'b0, 16'hFFFF, 13'h0ABC, 1'b1, 1'b0, 8'h5A, 13'h0101, 1'b1, 1'b1); // 10
        // Address wrap
        add(1'b0, 1'b1, 16'h1234, 13'h1FFF, 1'b1, 1'b1, 8'h12, 13'h1FFF, 1'b0, 1'b0); // 11
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b1, 8'h34, 13'h0000, 1'b0, 1'b0); // 12
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b0, 8'h34, 13'h0000, 1'b1, 1'b1); // 13
        // Start held high: second word ignored while busy, accepted in the done cycle
        add(1'b0, 1'b1, 16'h0102, 13'h0200, 1'b1, 1'b1, 8'h01, 13'h0200, 1'b0, 1'b0); // 14
        add(1'b0, 1'b1, 16'h0304, 13'h0300, 1'b1, 1'b1, 8'h02, 13'h0201, 1'b0, 1'b0); // 15
        add(1'b0, 1'b1, 16'h0304, 13'h0300, 1'b1, 1'b0, 8'h02, 13'h0201, 1'b1, 1'b1); // 16
        add(1'b0, 1'b1, 16'h0304, 13'h0300, 1'b1, 1'b1, 8'h03, 13'h0300, 1'b0, 1'b0); // 17
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b1, 8'h04, 13'h0301, 1'b0, 1'b0); // 18
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b0, 8'h04, 13'h0301, 1'b1, 1'b1); // 19
        // Reset during SECOND aborts the word; rst beats start and mem_rdy
        add(1'b0, 1'b1, 16'hCAFE, 13'h0400, 1'b1, 1'b1, 8'hCA, 13'h0400, 1'b0, 1'b0); // 20
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b1, 8'hFE, 13'h0401, 1'b0, 1'b0); // 21
        add(1'b1, 1'b1, 16'h5555, 13'h0555, 1'b1, 1'b0, 8'h00, 13'h0000, 1'b1, 1'b0); // 22
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b1, 1'b0, 8'h00, 13'h0000, 1'b1, 1'b0); // 23
        add(1'b0, 1'b0, 16'h0000, 13'h0000, 1'b0, 1'b0, 8'h00, 13'h0000, 1'b1, 1'b0); // 24

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; start = vecs[i].start; word = vecs[i].word;
            addr = vecs[i].addr; mem_rdy = vecs[i].mem_rdy;
            @(posedge clk);
            #1;
            check($sformatf("row%0d wr", i), 32'(wr), 32'(vecs[i].e_wr));
            check($sformatf("row%0d data_out", i), 32'(data_out), 32'(vecs[i].e_data));
            check($sformatf("row%0d addr_out", i), 32'(addr_out), 32'(vecs[i].e_addr));
            check($sformatf("row%0d ready", i), 32'(ready), 32'(vecs[i].e_ready));
            check($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].e_done));
            if (i == 0) begin
                check("lo reset ready", 32'(ready_lo), 32'd1);
                check("lo reset wr", 32'(wr_lo), 32'd0);
            end
        end

        // Low-byte-first instance: BEEF at 0x0010
        @(negedge clk);
        start_lo = 1'b1; word_lo = 16'hBEEF; addr_lo = 13'h0010; mem_rdy_lo = 1'b1;
        @(posedge clk); #1;
        check("lo first wr", 32'(wr_lo), 32'd1);
        check("lo first data", 32'(data_out_lo), 32'hEF);
        check("lo first addr", 32'(addr_out_lo), 32'h0010);
        @(negedge clk);
        start_lo = 1'b0; word_lo = 16'h0000;
        @(posedge clk); #1;
        check("lo second wr", 32'(wr_lo), 32'd1);
        check("lo second data", 32'(data_out_lo), 32'hBE);
        check("lo second addr", 32'(addr_out_lo), 32'h0011);

        // done must arrive within a bounded number of cycles
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                @(posedge clk); #1;
                if (done_lo) seen = 1'b1;
            end
            check("lo done seen", 32'(seen), 32'd1);
            check("lo ready after done", 32'(ready_lo), 32'd1);
            check("lo wr after done", 32'(wr_lo), 32'd0);
        end
        @(posedge clk); #1;
        check("lo done one cycle", 32'(done_lo), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
